// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops and bit-serial
// logical right shifts, with valid/ready handshakes on request and result.
module alu_exec_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [3:0]         ALUCtrl_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               zero_o
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NAND  = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_ADDU  = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_EQUAL = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRLV  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_W-1:0]    shift_reg;
    logic [SHAMT_W-1:0]   count;

    logic [DATA_W-1:0]    alu_res_c;
    logic                 shift_op_c;
    logic [SHAMT_W-1:0]   shift_amt_c;
    logic                 slt_c;
    logic [DATA_W-1:0]    shift_next_c;

    // Single-cycle result; for shifts this is the zero-amount case (operand passes through)
    always_comb begin
        alu_res_c   = '0;
        shift_op_c  = 1'b0;
        shift_amt_c = '0;
        slt_c       = ($signed(src1_i) < $signed(src2_i));
        case (ALUCtrl_i)
            OP_AND:   alu_res_c = src1_i & src2_i;
            OP_OR:    alu_res_c = src1_i | src2_i;
            OP_NAND:  alu_res_c = ~(src1_i & src2_i);
            OP_NOR:   alu_res_c = ~(src1_i | src2_i);
            OP_ADDU:  alu_res_c = src1_i + src2_i;
            OP_SUBU:  alu_res_c = src1_i - src2_i;
            OP_SLT:   alu_res_c = DATA_W'(slt_c);
            OP_EQUAL: alu_res_c = DATA_W'(src1_i == src2_i);
            OP_SRL: begin
                alu_res_c   = src2_i;
                shift_op_c  = 1'b1;
                shift_amt_c = shamt_i;
            end
            OP_SRLV: begin
                alu_res_c   = src2_i;
                shift_op_c  = 1'b1;
                shift_amt_c = src1_i[SHAMT_W-1:0];
            end
            default:  alu_res_c = '0;
        endcase
    end

    // One-bit logical right shift of the serial shifter
    always_comb begin
        shift_next_c = shift_reg >> 1;
    end

    // Control FSM, shifter and registered handshake/result outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            count     <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i && ready_o) begin
                        ready_o <= 1'b0;
                        if (shift_op_c && (shift_amt_c != '0)) begin
                            shift_reg <= src2_i;
                            count     <= shift_amt_c;
                            state     <= ST_SHIFT;
                        end else begin
                            result_o <= alu_res_c;
                            zero_o   <= (alu_res_c == '0);
                            valid_o  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_next_c;
                    count     <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        result_o <= shift_next_c;
                        zero_o   <= (shift_next_c == '0);
                        valid_o  <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit with a transaction-level model.
module tb_alu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  ALUCtrl_i = 4'd0;
    logic [31:0] src1_i = 32'd0;
    logic [31:0] src2_i = 32'd0;
    logic [4:0]  shamt_i = 5'd0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o;

    int checks = 0;
    int passes = 0;

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .shamt_i   (shamt_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .zero_o    (zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Architectural result of an operation
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return ~(a & b);
            4'd3: return ~(a | b);
            4'd4: return a + b;
            4'd5: return a - b;
            4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: return (a == b) ? 32'd1 : 32'd0;
            4'd8: return b >> sh;
            4'd9: return b >> a[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Clock edges from the accept edge until the result is visible (0 = right after accept)
    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a, input logic [4:0] sh);
        if (op == 4'd8) return int'(sh);
        if (op == 4'd9) return int'(a[4:0]);
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: busy from accept until the result handshake
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_res   = 32'd0;
    bit          m_zero  = 1'b0;
    logic [31:0] m_pend  = 32'd0;
    int          m_done  = 0;
    int          cyc     = 0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_res   = 32'd0;
            m_zero  = 1'b0;
        end else begin
            cyc++;
            if (m_valid && ready_i) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end else if (!m_busy && valid_i) begin
                m_pend = ref_result(ALUCtrl_i, src1_i, src2_i, shamt_i);
                m_done = cyc + ref_latency(ALUCtrl_i, src1_i, shamt_i);
                m_busy = 1'b1;
            end
            if (m_busy && !m_valid && cyc == m_done) begin
                m_valid = 1'b1;
                m_res   = m_pend;
                m_zero  = (m_pend == 32'd0);
            end
        end
    end

    // Every-cycle comparison of the outputs against the model
    always @(negedge clk_i) begin
        chk("ready_o", 32'(ready_o), 32'(!m_busy));
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        chk("result_o", result_o, m_res);
        chk("zero_o", 32'(zero_o), 32'(m_zero));
    end

    // Issue one request and complete its result handshake
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int stall, input bit pulse,
                         input bit lit, input logic [31:0] er, input bit ez, input int el);
        int t;
        int lat;
        t = 0;
        while (ready_o !== 1'b1 && t < 200) begin
            @(posedge clk_i); #1; t++;
        end
        if (t >= 200) chk("accept_timeout", 32'(t), 32'd0);
        ALUCtrl_i = op; src1_i = a; src2_i = b; shamt_i = sh; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ALUCtrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom; shamt_i = 5'($urandom);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 100) begin
            valid_i = pulse && (lat == 1);
            @(posedge clk_i); #1; lat++;
        end
        valid_i = 1'b0;
        if (lat >= 100) chk("result_timeout", 32'(lat), 32'd0);
        if (lit) begin
            chk("lit_latency", 32'(lat), 32'(el));
            chk("lit_result", result_o, er);
            chk("lit_zero", 32'(zero_o), 32'(ez));
        end
        repeat (stall) begin
            @(posedge clk_i); #1;
        end
        if (lit && stall > 0) begin
            chk("lit_stall_valid", 32'(valid_o), 32'd1);
            chk("lit_stall_result", result_o, er);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        if (lit) begin
            chk("lit_post_valid", 32'(valid_o), 32'd0);
            chk("lit_post_ready", 32'(ready_o), 32'd1);
            chk("lit_post_result", result_o, er);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_zero", 32'(zero_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        do_op(4'd4, 32'hFFFF_FFFF, 32'h2, 5'd0, 0, 0, 1, 32'h1, 1'b0, 0);
        do_op(4'd6, 32'h8000_0000, 32'h1, 5'd0, 0, 0, 1, 32'h1, 1'b0, 0);
        do_op(4'd5, 32'd5, 32'd5, 5'd0, 1, 0, 1, 32'h0, 1'b1, 0);
        do_op(4'd7, 32'd7, 32'd7, 5'd0, 0, 0, 1, 32'h1, 1'b0, 0);
        do_op(4'd3, 32'd0, 32'd0, 5'd0, 0, 0, 1, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(4'd8, 32'h0, 32'h8000_0000, 5'd31, 0, 0, 1, 32'h1, 1'b0, 31);
        do_op(4'd8, 32'h0, 32'h8000_0000, 5'd0, 0, 0, 1, 32'h8000_0000, 1'b0, 0);
        do_op(4'd9, 32'h24, 32'hF0, 5'd0, 5, 1, 1, 32'hF, 1'b0, 4);
        do_op(4'd12, 32'h1234, 32'h5678, 5'd3, 0, 0, 1, 32'h0, 1'b1, 0);
        do_op(4'd2, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0, 0, 0, 1, 32'h00FF_FFFF, 1'b0, 0);
        do_op(4'd9, 32'hFFFF_FFE1, 32'h1, 5'd0, 0, 0, 1, 32'h0, 1'b1, 1);

        // Reset in the middle of a shift with ten steps remaining
        ALUCtrl_i = 4'd8; src1_i = 32'd0; src2_i = 32'hFFFF_0000; shamt_i = 5'd20; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        do_op(4'd1, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 0, 0, 1, 32'h0F0F_00F0, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = a & 32'h7;
            if ($urandom_range(0, 3) == 0) b = a;
            do_op(op, a, b, 5'($urandom_range(0, 12)), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, 0, 32'd0, 1'b0, 0);
        end

        repeat (3) @(posedge clk_i);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
